csr_hpm_counter_bank: RTL and testbench

//  Parametrised machine-mode hardware performance monitor (HPM) counter bank, sitting beside the CSR unit.
//  It provides NUM_COUNTERS programmable mhpmcounter/mhpmevent pairs, mcountinhibit and a sticky overflow CSR.
//  It counts selectable pipeline events (multi-count per cycle) and raises a level overflow interrupt request.
//  The CSR unit forwards csrNumber/csrWE/csrCode/csrWriteIn and muxes csrReadOut when csrHit is high.

---
 rtl/csr_hpm_counter_bank_pkg.sv | 35 +++
 rtl/csr_hpm_counter_bank_hpm_counter.sv | 53 +++++
 rtl/csr_hpm_counter_bank.sv | 176 +++++++++++++++++
 tb/tb_csr_hpm_counter_bank.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_hpm_counter_bank_pkg.sv
// Shared CSR numbers, access codes and event-configuration types for the
// hardware performance monitor counter bank.
package csr_hpm_counter_bank_pkg;

  localparam logic [11:0] CSR_NUM_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_NUM_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_NUM_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_NUM_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_NUM_MHPMOVF       = 12'h7C0;

  // mcountinhibit bit of the first implemented HPM counter.
  localparam int HPM_FIRST_COUNTER = 3;
  // mhpmevent bit carrying the per-counter overflow interrupt enable.
  localparam int HPM_EVT_IRQ_EN_BIT = 31;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_code_e;

  typedef logic [7:0] HPM_EventSelPath;

  typedef struct packed {
    logic            ovfIrqEn;
    HPM_EventSelPath sel;
  } HPM_EventCfgPath;

  // Selector 0 means "no event"; values past the last channel are stored but inert.
  function automatic logic hpm_sel_valid(input HPM_EventSelPath sel, input int num_events);
    return (sel != '0) && (int'(sel) <= num_events);
  endfunction

endpackage

// File: rtl/csr_hpm_counter_bank_hpm_counter.sv
// One HPM counter slice: a wide counter that adds a small per-cycle increment,
// accepts half-word CSR writes and reports the carry out of its MSB.
module csr_hpm_counter_bank_hpm_counter
  import csr_hpm_counter_bank_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int INC_WIDTH     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [INC_WIDTH-1:0]     inc_i,
  input  logic                     enable_i,
  input  logic                     wr_lo_i,
  input  logic                     wr_hi_i,
  input  logic [DATA_WIDTH-1:0]    wv_i,
  output logic [COUNTER_WIDTH-1:0] cnt_o,
  output logic                     carry_o
);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH:0]   sum;

  assign sum = {1'b0, cnt_q} + {{(COUNTER_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_i};

  // Next count: a CSR write to either half wins and drops this cycle's increment.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[DATA_WIDTH-1:0] = wv_i;
    end else if (wr_hi_i) begin
      cnt_d[COUNTER_WIDTH-1:DATA_WIDTH] = wv_i[COUNTER_WIDTH-DATA_WIDTH-1:0];
    end else if (enable_i) begin
      cnt_d = sum[COUNTER_WIDTH-1:0];
    end
  end

  // A dropped increment must not report an overflow either.
  assign carry_o = enable_i & ~wr_lo_i & ~wr_hi_i & sum[COUNTER_WIDTH];
  assign cnt_o   = cnt_q;

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csr_hpm_counter_bank.sv
// Machine-mode HPM counter bank: CSR decode and read mux, mcountinhibit,
// per-counter event configuration, sticky overflow CSR, registered event
// inputs and the level overflow interrupt request.
module csr_hpm_counter_bank
  import csr_hpm_counter_bank_pkg::*;
#(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int INC_WIDTH     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [11:0]                      csrNumber_i,
  input  logic                             csrWE_i,
  input  logic [1:0]                       csrCode_i,
  input  logic [DATA_WIDTH-1:0]            csrWriteIn_i,
  output logic [DATA_WIDTH-1:0]            csrReadOut_o,
  output logic                             csrHit_o,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0]  eventInc_i,
  output logic                             overflowIrq_o,
  output logic [NUM_COUNTERS-1:0]          overflowVec_o
);

  localparam int NC = NUM_COUNTERS;
  localparam int DW = DATA_WIDTH;
  localparam int CW = COUNTER_WIDTH;
  localparam int IW = INC_WIDTH;

  // Architectural state
  HPM_EventCfgPath               cfg_q [NC];
  logic [NC-1:0]                 inhibit_q;
  logic [NC-1:0]                 ovf_q, ovf_d;
  logic [NUM_EVENTS*IW-1:0]      ev_inc_q;
  logic                          irq_q;

  // Decode / datapath
  logic                          hit;
  logic [DW-1:0]                 rd;
  logic [DW-1:0]                 wv;
  logic                          we;
  logic                          sel_inh, sel_ovf;
  logic [NC-1:0]                 sel_lo, sel_hi, sel_ev;
  logic [NC-1:0]                 wr_lo, wr_hi;
  logic [NC-1:0]                 ovf_clr;
  logic [NC-1:0]                 irq_en;
  logic [NC-1:0]                 cnt_en;
  logic [NC-1:0]                 carry;
  logic [IW-1:0]                 inc [NC];
  logic [CW-1:0]                 cnt [NC];

  // Address decode and read mux; unaddressed or foreign CSRs read 0.
  always_comb begin
    hit     = 1'b0;
    rd      = '0;
    sel_inh = 1'b0;
    sel_ovf = 1'b0;
    sel_lo  = '0;
    sel_hi  = '0;
    sel_ev  = '0;
    if (csrNumber_i == CSR_NUM_MCOUNTINHIBIT) begin
      hit = 1'b1;
      sel_inh = 1'b1;
      rd[HPM_FIRST_COUNTER +: NC] = inhibit_q;
    end
    if (csrNumber_i == CSR_NUM_MHPMOVF) begin
      hit = 1'b1;
      sel_ovf = 1'b1;
      rd[NC-1:0] = ovf_q;
    end
    for (int i = 0; i < NC; i++) begin
      if (csrNumber_i == CSR_NUM_MHPMCOUNTER3 + 12'(i)) begin
        hit = 1'b1;
        sel_lo[i] = 1'b1;
        rd = cnt[i][DW-1:0];
      end
      if (csrNumber_i == CSR_NUM_MHPMCOUNTER3H + 12'(i)) begin
        hit = 1'b1;
        sel_hi[i] = 1'b1;
        rd = DW'(cnt[i][CW-1:DW]);
      end
      if (csrNumber_i == CSR_NUM_MHPMEVENT3 + 12'(i)) begin
        hit = 1'b1;
        sel_ev[i] = 1'b1;
        rd[HPM_EVT_IRQ_EN_BIT] = cfg_q[i].ovfIrqEn;
        rd[7:0] = cfg_q[i].sel;
      end
    end
  end

  // Write value from the access code, applied to the current read value.
  always_comb begin
    unique case (csr_code_e'(csrCode_i))
      CSR_WRITE: wv = csrWriteIn_i;
      CSR_SET:   wv = rd | csrWriteIn_i;
      CSR_CLEAR: wv = rd & ~csrWriteIn_i;
      default:   wv = rd;
    endcase
  end

  assign we      = csrWE_i & hit;
  assign wr_lo   = sel_lo & {NC{we}};
  assign wr_hi   = sel_hi & {NC{we}};
  // mhpmovf ignores the access code: the operand is always a write-1-to-clear mask.
  assign ovf_clr = (we && sel_ovf) ? csrWriteIn_i[NC-1:0] : '0;
  // A fresh overflow on the same edge beats a concurrent clear.
  assign ovf_d   = (ovf_q & ~ovf_clr) | carry;

  // Route each counter's selected, registered event channel to its slice.
  always_comb begin
    cnt_en = '0;
    irq_en = '0;
    for (int i = 0; i < NC; i++) begin
      inc[i]    = '0;
      irq_en[i] = cfg_q[i].ovfIrqEn;
      cnt_en[i] = ~inhibit_q[i] & hpm_sel_valid(cfg_q[i].sel, NUM_EVENTS);
      for (int k = 0; k < NUM_EVENTS; k++) begin
        if (cfg_q[i].sel == HPM_EventSelPath'(k + 1)) begin
          inc[i] = ev_inc_q[k*IW +: IW];
        end
      end
    end
  end

  for (genvar g = 0; g < NC; g++) begin : g_counter
    csr_hpm_counter_bank_hpm_counter #(
      .COUNTER_WIDTH (CW),
      .DATA_WIDTH    (DW),
      .INC_WIDTH     (IW)
    ) u_counter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (inc[g]),
      .enable_i (cnt_en[g]),
      .wr_lo_i  (wr_lo[g]),
      .wr_hi_i  (wr_hi[g]),
      .wv_i     (wv),
      .cnt_o    (cnt[g]),
      .carry_o  (carry[g])
    );
  end

  // Configuration, overflow, event-input pipeline and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit_q <= '1;
      ovf_q     <= '0;
      ev_inc_q  <= '0;
      irq_q     <= 1'b0;
      // NOTE: the event-config array is a handful of flops, not a RAM, so every entry is reset.
      for (int i = 0; i < NC; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      ev_inc_q <= eventInc_i;
      ovf_q    <= ovf_d;
      irq_q    <= |(ovf_q & irq_en);
      if (we && sel_inh) begin
        inhibit_q <= wv[HPM_FIRST_COUNTER +: NC];
      end
      for (int i = 0; i < NC; i++) begin
        if (we && sel_ev[i]) begin
          cfg_q[i].sel      <= wv[7:0];
          cfg_q[i].ovfIrqEn <= wv[HPM_EVT_IRQ_EN_BIT];
        end
      end
    end
  end

  assign csrReadOut_o  = rd;
  assign csrHit_o      = hit;
  assign overflowIrq_o = irq_q;
  assign overflowVec_o = ovf_q;

endmodule

// File: tb/tb_csr_hpm_counter_bank.sv
// Self-checking bench for csr_hpm_counter_bank: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_csr_hpm_counter_bank;
  import csr_hpm_counter_bank_pkg::*;

  localparam int NC = 4;
  localparam int NE = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   csr_num;
  logic          csr_we;
  logic [1:0]    csr_code;
  logic [31:0]   csr_in;
  logic [31:0]   rd_out;
  logic          hit;
  logic [NE*IW-1:0] ev_in;
  logic          irq;
  logic [NC-1:0] vec;

  always #5 clk = ~clk;

  csr_hpm_counter_bank #(
    .NUM_COUNTERS  (NC),
    .NUM_EVENTS    (NE),
    .COUNTER_WIDTH (64),
    .DATA_WIDTH    (32),
    .INC_WIDTH     (IW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .csrNumber_i   (csr_num),
    .csrWE_i       (csr_we),
    .csrCode_i     (csr_code),
    .csrWriteIn_i  (csr_in),
    .csrReadOut_o  (rd_out),
    .csrHit_o      (hit),
    .eventInc_i    (ev_in),
    .overflowIrq_o (irq),
    .overflowVec_o (vec)
  );

  // Reference model state
  logic [63:0]   m_cnt [NC];
  logic [7:0]    m_sel [NC];
  logic [NC-1:0] m_ien;
  logic [NC-1:0] m_inh;
  logic [NC-1:0] m_ovf;
  logic          m_irq;
  int unsigned   m_evreg [NE];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [11:0] n);
    int a = int'(n);
    if (a == 'h320 || a == 'h7C0) return 1'b1;
    if (a >= 'hB03 && a < 'hB03 + NC) return 1'b1;
    if (a >= 'hB83 && a < 'hB83 + NC) return 1'b1;
    if (a >= 'h323 && a < 'h323 + NC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] n);
    int a = int'(n);
    logic [31:0] r = '0;
    if (a == 'h320) begin
      for (int i = 0; i < NC; i++) r[3+i] = m_inh[i];
    end else if (a == 'h7C0) begin
      r[NC-1:0] = m_ovf;
    end else if (a >= 'hB03 && a < 'hB03 + NC) begin
      r = m_cnt[a - 'hB03][31:0];
    end else if (a >= 'hB83 && a < 'hB83 + NC) begin
      r = m_cnt[a - 'hB83][63:32];
    end else if (a >= 'h323 && a < 'h323 + NC) begin
      r = {m_ien[a - 'h323], 23'd0, m_sel[a - 'h323]};
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_step();
    logic [31:0]   rdv, wv;
    logic          wr;
    logic [NC-1:0] nov;
    logic [64:0]   s;
    int            a;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = '0;
        m_sel[i] = '0;
      end
      for (int k = 0; k < NE; k++) m_evreg[k] = 0;
      m_ien = '0;
      m_inh = '1;
      m_ovf = '0;
      m_irq = 1'b0;
      return;
    end
    a   = int'(csr_num);
    rdv = m_read(csr_num);
    wr  = csr_we && m_hit(csr_num);
    case (csr_code)
      CSR_WRITE: wv = csr_in;
      CSR_SET:   wv = rdv | csr_in;
      CSR_CLEAR: wv = rdv & ~csr_in;
      default:   wv = rdv;
    endcase
    nov = m_ovf;
    if (wr && a == 'h7C0) nov = nov & ~csr_in[NC-1:0];
    for (int i = 0; i < NC; i++) begin
      if (wr && a == 'hB03 + i) begin
        m_cnt[i][31:0] = wv;
      end else if (wr && a == 'hB83 + i) begin
        m_cnt[i][63:32] = wv;
      end else if (!m_inh[i] && m_sel[i] >= 1 && int'(m_sel[i]) <= NE) begin
        s = {1'b0, m_cnt[i]} + 65'(m_evreg[int'(m_sel[i]) - 1]);
        m_cnt[i] = s[63:0];
        if (s[64]) nov[i] = 1'b1;
      end
    end
    m_irq = |(m_ovf & m_ien);
    for (int i = 0; i < NC; i++) begin
      if (wr && a == 'h323 + i) begin
        m_sel[i] = wv[7:0];
        m_ien[i] = wv[31];
      end
    end
    if (wr && a == 'h320) m_inh = wv[3 +: NC];
    m_ovf = nov;
    for (int k = 0; k < NE; k++) m_evreg[k] = int'(ev_in[k*IW +: IW]);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check("irq", irq, m_irq);
    check("ovf_vec", vec, m_ovf);
  endtask

  task automatic csr_write(input logic [11:0] n, input logic [1:0] code, input logic [31:0] v);
    csr_num  = n;
    csr_we   = 1'b1;
    csr_code = code;
    csr_in   = v;
    tick();
    csr_we   = 1'b0;
  endtask

  // Read with a fixed expectation and a model cross-check.
  task automatic rd_check(input string tag, input logic [11:0] n, input logic [31:0] exp);
    csr_num = n;
    csr_we  = 1'b0;
    #1;
    check(tag, rd_out, exp);
    check({tag, "_model"}, rd_out, m_read(n));
    check({tag, "_hit"}, hit, m_hit(n));
  endtask

  task automatic rd_mcheck(input logic [11:0] n);
    csr_num = n;
    csr_we  = 1'b0;
    #1;
    check("rnd_rd", rd_out, m_read(n));
    check("rnd_hit", hit, m_hit(n));
  endtask

  function automatic logic [11:0] rnd_addr();
    int idx = int'($urandom_range(0, NC));
    case ($urandom_range(0, 4))
      0: return 12'(32'hB03 + idx);
      1: return 12'(32'hB83 + idx);
      2: return 12'(32'h323 + idx);
      3: return 12'h320;
      default: return 12'h7C0;
    endcase
  endfunction

  initial begin
    logic [11:0] a;
    logic [31:0] v;
    int          r;

    rst = 1'b1; csr_num = '0; csr_we = 1'b0; csr_code = CSR_WRITE; csr_in = '0; ev_in = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rd_check("rst_cnt3", 12'hB03, 32'h0);
    rd_check("rst_evt3", 12'h323, 32'h0);
    rd_check("rst_ovf", 12'h7C0, 32'h0);
    rd_check("rst_inhibit", 12'h320, 32'h78);
    check("rst_irq", irq, 1'b0);

    // Basic counting on channel 1 with two-cycle visibility
    csr_write(12'h320, CSR_CLEAR, 32'h8);
    csr_write(12'h323, CSR_WRITE, 32'h2);
    for (int k = 1; k <= 7; k++) begin
      ev_in = (k <= 5) ? 16'h000C : 16'h0000;
      tick();
      rd_check("cnt_latency", 12'hB03, 32'(3 * ((k - 1) > 5 ? 5 : (k - 1))));
    end

    // 64-bit wrap sets sticky overflow; IRQ follows one cycle later
    ev_in = '0;
    csr_write(12'hB83, CSR_WRITE, 32'hFFFF_FFFF);
    csr_write(12'hB03, CSR_WRITE, 32'hFFFF_FFFE);
    csr_write(12'h323, CSR_WRITE, 32'h8000_0002);
    ev_in = 16'h000C;
    tick();
    ev_in = '0;
    tick();
    check("wrap_ovf0", vec[0], 1'b1);
    check("wrap_irq_not_yet", irq, 1'b0);
    rd_check("wrap_lo", 12'hB03, 32'h1);
    rd_check("wrap_hi", 12'hB83, 32'h0);
    tick();
    check("wrap_irq", irq, 1'b1);

    // Low-half write collides with a landing increment
    csr_write(12'hB83, CSR_WRITE, 32'h5);
    ev_in = 16'h0008;
    tick();
    ev_in = '0;
    csr_write(12'hB03, CSR_WRITE, 32'h100);
    tick();
    rd_check("wr_drop_lo", 12'hB03, 32'h100);
    rd_check("wr_drop_hi", 12'hB83, 32'h5);

    // Overflow set beats concurrent clear; a lone clear drops IRQ next cycle
    csr_write(12'hB83, CSR_WRITE, 32'hFFFF_FFFF);
    csr_write(12'hB03, CSR_WRITE, 32'hFFFF_FFFF);
    ev_in = 16'h0004;
    tick();
    ev_in = '0;
    csr_write(12'h7C0, CSR_WRITE, 32'h1);
    check("set_wins", vec[0], 1'b1);
    rd_check("set_wins_cnt", 12'hB03, 32'h0);
    csr_write(12'h7C0, CSR_CLEAR, 32'h1);
    check("ovf_cleared", vec[0], 1'b0);
    check("irq_still_high", irq, 1'b1);
    tick();
    check("irq_dropped", irq, 1'b0);

    // Inhibit freezes the counter; out-of-range selector counts nothing
    csr_write(12'h320, CSR_SET, 32'h8);
    rd_check("inhibit_reg", 12'h320, 32'h78);
    ev_in = 16'h000C;
    for (int k = 0; k < 4; k++) tick();
    ev_in = '0;
    tick();
    tick();
    rd_check("inhibit_frozen", 12'hB03, 32'h0);
    csr_write(12'h320, CSR_CLEAR, 32'h8);
    csr_write(12'h323, CSR_WRITE, 32'h9);
    ev_in = 16'hFFFF;
    for (int k = 0; k < 4; k++) tick();
    ev_in = '0;
    tick();
    tick();
    rd_check("sel9_frozen", 12'hB03, 32'h0);
    rd_check("sel9_stored", 12'h323, 32'h9);
    rd_check("unimpl_b07", 12'hB07, 32'h0);
    check("unimpl_b07_hit", hit, 1'b0);
    rd_check("unimpl_b87", 12'hB87, 32'h0);
    rd_check("unimpl_327", 12'h327, 32'h0);

    // Randomized traffic against the model
    csr_write(12'h320, CSR_WRITE, 32'h0);
    for (int i = 0; i < NC; i++) begin
      csr_write(12'(32'h323 + i), CSR_WRITE, {1'b1, 23'd0, 8'($urandom_range(1, NE))});
    end
    for (int c = 0; c < 600; c++) begin
      ev_in = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        a = rnd_addr();
        v = $urandom;
        if (a >= 12'hB83 && a < 12'hB87 && $urandom_range(0, 1) == 1) v = 32'hFFFF_FFFF;
        if (a >= 12'hB03 && a < 12'hB07 && $urandom_range(0, 1) == 1) v = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (a >= 12'h323 && a < 12'h327) v = {v[31], 23'd0, 8'($urandom_range(0, 10))};
        if (a == 12'h320) v = v & 32'h78;
        csr_write(a, 2'($urandom_range(0, 3)), v);
      end else if (r < 7) begin
        rd_mcheck(rnd_addr());
        tick();
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
